regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (rd / write_data / reg_write) between two writeback requesters.
  - Requester 0: in-order pipeline writeback.
  - Requester 1: long-latency unit (load / mul-div).
- Keeps a per-register busy scoreboard, set at issue and cleared when the write retires.
- Reports operand hazards for the decode-stage rs1/rs2, so the pipeline stalls until pending writes complete.

Parameters:
- REG_WIDTH, 32, data width of write_data.
- ADDR_WIDTH, 5, register address width; the scoreboard has 1<<ADDR_WIDTH entries.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- wb0_valid  input  1  requester 0 has a write pending.
- wb0_ready  output  1  requester 0 write accepted this cycle.
- wb0_rd  input  ADDR_WIDTH  requester 0 destination.
- wb0_data  input  REG_WIDTH  requester 0 data.
- wb1_valid / wb1_ready / wb1_rd / wb1_data: same as requester 0, for requester 1.
- hold  input  1  blocks all grants while high.
- issue_valid  input  1  an instruction with destination issue_rd is issued this cycle.
- issue_rd  input  ADDR_WIDTH  destination to mark busy.
- rs1  input  ADDR_WIDTH  decode operand 1 to check.
- rs2  input  ADDR_WIDTH  decode operand 2 to check.
- rs1_busy  output  1  rs1 has a pending write.
- rs2_busy  output  1  rs2 has a pending write.
- rd  output  ADDR_WIDTH  to register file.
- write_data  output  REG_WIDTH  to register file.
- reg_write  output  1  to register file.
- busy_vec  output  1<<ADDR_WIDTH  scoreboard state.

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - busy_vec = 0.
  - reg_write = 0, rd = 0, write_data = 0.
  - Priority pointer last_grant = 1, so requester 0 wins the first contention.
- Handshake: valid/ready per requester.
  - A transfer occurs when valid && ready.
  - ready is combinational from valid, hold and last_grant.
  - A requester holds valid, rd and data stable until accepted.
- Grant rules:
  - hold = 1: no grant; both ready = 0.
  - Only one requester valid: it is granted.
  - Both valid: round-robin. Grant the requester that is not last_grant, then update last_grant.
  - last_grant changes only on a grant.
- Output stage is registered. Latency from accept cycle N:
  - reg_write = 1 in cycle N+1, with rd and write_data of the granted requester.
  - No grant in cycle N gives reg_write = 0 in N+1; rd and write_data hold their previous values.
- Register x0:
  - An accepted write with rd = 0 is consumed (ready = 1) but produces reg_write = 0.
  - The scoreboard never sets bit 0. issue_rd = 0 is ignored.
- Scoreboard update, per clock edge:
  - Set busy[issue_rd] if issue_valid.
  - Clear busy[wb_rd] at the accept cycle N, not at N+1.
  - Same register set and cleared in the same cycle: set wins. The new instruction's write is still pending.
- Hazard outputs:
  - rs1_busy = busy_vec[rs1], computed combinationally from the registered vector, with no bypass of a same-cycle clear.
  - rs2_busy is computed the same way from rs2.
  - rs1 = 0 or rs2 = 0 always gives not busy.
- Reset mid-operation:
  - Pending grants are dropped, the scoreboard is cleared, and reg_write is 0 in the cycle after the reset edge.
  - A valid still asserted after reset deasserts is arbitrated as a fresh request.
- Scoreboard misuse: no counting of multiple outstanding writes to one register. Issuing the same rd twice before retirement is illegal for the pipeline; the block's behaviour then is simply the bit semantics above.

Test Plan:
1. Reset, then idle → reg_write = 0, busy_vec = 0, rs1_busy = 0 for rs1 = 5, wb0_ready = wb1_ready = 0.
2. issue_valid with issue_rd = 7; next cycle rs1 = 7 → rs1_busy = 1. Then wb1_valid, rd = 7, data = 0xDEADBEEF → wb1_ready = 1 that cycle; next cycle reg_write = 1, rd = 7, write_data = 0xDEADBEEF, busy_vec[7] = 0.
3. Both requesters valid for 4 consecutive cycles (wb0 rd = 1, 2, 3, 4; wb1 rd = 9, 10, 11, 12, each re-presented until accepted) → grants alternate 0, 1, 0, 1. reg_write stream rd = 1, 9, 2, 10 on consecutive cycles with no bubble.
4. hold = 1 for 3 cycles with wb0_valid → wb0_ready = 0 and reg_write = 0 throughout. hold falls → accept next cycle, write the cycle after.
5. Same cycle: issue_valid, issue_rd = 3, and wb0 accepted with rd = 3 → busy_vec[3] = 1 afterwards; reg_write rd = 3 still occurs.
6. wb0 write with rd = 0, data = 0x1234 → wb0_ready = 1, reg_write = 0 next cycle. issue_rd = 0 → busy_vec[0] stays 0. Assert rst mid-stream with busy_vec = 0x0000_0088 → busy_vec = 0 and reg_write = 0 next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between two writeback requesters,
// with a per-register busy scoreboard and decode-stage operand hazard outputs.
module regfile_wb_arbiter #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb0_valid,
    output logic                       wb0_ready,
    input  logic [ADDR_WIDTH-1:0]      wb0_rd,
    input  logic [REG_WIDTH-1:0]       wb0_data,
    input  logic                       wb1_valid,
    output logic                       wb1_ready,
    input  logic [ADDR_WIDTH-1:0]      wb1_rd,
    input  logic [REG_WIDTH-1:0]       wb1_data,
    input  logic                       hold,
    input  logic                       issue_valid,
    input  logic [ADDR_WIDTH-1:0]      issue_rd,
    input  logic [ADDR_WIDTH-1:0]      rs1,
    input  logic [ADDR_WIDTH-1:0]      rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic [ADDR_WIDTH-1:0]      rd,
    output logic [REG_WIDTH-1:0]       write_data,
    output logic                       reg_write,
    output logic [(1<<ADDR_WIDTH)-1:0] busy_vec
);
    localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

    logic                  r_last_grant;
    logic [NumRegs-1:0]    r_busy;
    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [REG_WIDTH-1:0]  r_write_data;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_gnt_rd;
    logic [REG_WIDTH-1:0]  w_gnt_data;
    logic [NumRegs-1:0]    w_busy_d;

    // Requester 0 wins a contention only if requester 1 took the previous grant.
    // No transfer is accepted while reset is asserted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && !hold) begin
            if (wb0_valid && (!wb1_valid || r_last_grant)) begin
                w_gnt0 = 1'b1;
            end else if (wb1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_any      = w_gnt0 | w_gnt1;
    assign w_gnt_rd   = w_gnt1 ? wb1_rd : wb0_rd;
    assign w_gnt_data = w_gnt1 ? wb1_data : wb0_data;

    // Clear on accept, then set on issue so a same-cycle reissue stays pending.
    always_comb begin
        w_busy_d = r_busy;
        if (w_any) begin
            w_busy_d[w_gnt_rd] = 1'b0;
        end
        if (issue_valid) begin
            w_busy_d[issue_rd] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_busy       <= '0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_write_data <= '0;
        end else begin
            r_busy      <= w_busy_d;
            r_reg_write <= w_any && (w_gnt_rd != '0);
            if (w_any) begin
                r_last_grant <= w_gnt1;
                r_rd         <= w_gnt_rd;
                r_write_data <= w_gnt_data;
            end
        end
    end

    assign wb0_ready  = w_gnt0;
    assign wb1_ready  = w_gnt1;
    assign reg_write  = r_reg_write;
    assign rd         = r_rd;
    assign write_data = r_write_data;
    assign busy_vec   = r_busy;
    assign rs1_busy   = (rs1 != '0) && r_busy[rs1];
    assign rs2_busy   = (rs2 != '0) && r_busy[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then random traffic,
// checked against a behavioural model; a separate monitor checks the write stream.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
    logic [4:0]  wb0_rd, wb1_rd, issue_rd, rs1, rs2, rd;
    logic [31:0] wb0_data, wb1_data, write_data, busy_vec;
    logic        hold, issue_valid, rs1_busy, rs2_busy, reg_write;

    regfile_wb_arbiter #(.REG_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .hold(hold), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd(rd), .write_data(write_data), .reg_write(reg_write), .busy_vec(busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          due;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    bit  mon_en   = 0;

    // Reference state: busy flags per register and which requester was granted last.
    bit  m_busy[32];
    int  m_last = 1;

    // Stimulus shadows, copied onto the DUT inputs shortly after each rising edge.
    logic        s_rst, s_v0, s_v1, s_hold, s_iv;
    logic [4:0]  s_rd0, s_rd1, s_ird, s_rs1, s_rs2;
    logic [31:0] s_d0, s_d1;
    bit          acc0, acc1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic clear_in();
        s_rst = 0; s_v0 = 0; s_v1 = 0; s_hold = 0; s_iv = 0;
        s_rd0 = 0; s_rd1 = 0; s_ird = 0; s_rs1 = 0; s_rs2 = 0; s_d0 = 0; s_d1 = 0;
    endtask

    // One clock cycle: apply inputs, compare combinational outputs, advance the model.
    task automatic step();
        bit e0, e1;
        @(posedge clk);
        cyc++;
        #1;
        rst = s_rst; wb0_valid = s_v0; wb0_rd = s_rd0; wb0_data = s_d0;
        wb1_valid = s_v1; wb1_rd = s_rd1; wb1_data = s_d1; hold = s_hold;
        issue_valid = s_iv; issue_rd = s_ird; rs1 = s_rs1; rs2 = s_rs2;
        #2;
        // When both requesters want the port, the one not granted last time wins.
        e0 = !s_rst && !s_hold && s_v0 && (!s_v1 || m_last == 1);
        e1 = !s_rst && !s_hold && s_v1 && !e0;
        chk("wb0_ready", 64'(wb0_ready), 64'(e0));
        chk("wb1_ready", 64'(wb1_ready), 64'(e1));
        chk("busy_vec", 64'(busy_vec), 64'(model_vec()));
        chk("rs1_busy", 64'(rs1_busy), 64'(s_rs1 != 0 && m_busy[s_rs1]));
        chk("rs2_busy", 64'(rs2_busy), 64'(s_rs2 != 0 && m_busy[s_rs2]));
        if (s_rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_last = 1;
        end else begin
            if (e0) begin
                if (s_rd0 != 0) exp_q.push_back('{rd: s_rd0, data: s_d0, due: cyc + 1});
                m_busy[s_rd0] = 0;
                m_last = 0;
            end
            if (e1) begin
                if (s_rd1 != 0) exp_q.push_back('{rd: s_rd1, data: s_d1, due: cyc + 1});
                m_busy[s_rd1] = 0;
                m_last = 1;
            end
            if (s_iv && s_ird != 0) m_busy[s_ird] = 1;
        end
        acc0 = e0;
        acc1 = e1;
    endtask

    // Write-port monitor: each expected write must appear exactly in its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("reg_write", 64'(reg_write), 64'(1));
                chk("wr_rd", 64'(rd), 64'(e.rd));
                chk("wr_data", 64'(write_data), 64'(e.data));
            end else begin
                chk("reg_write_idle", 64'(reg_write), 64'(0));
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    void'(exp_q.pop_front());
                    chk("write_missed", 64'(1), 64'(0));
                end
            end
        end
    end

    int gseq[4];

    initial begin
        clear_in();
        rst = 1; wb0_valid = 0; wb1_valid = 0; hold = 0; issue_valid = 0;
        wb0_rd = 0; wb1_rd = 0; wb0_data = 0; wb1_data = 0; issue_rd = 0; rs1 = 0; rs2 = 0;

        // 1: reset then idle
        s_rst = 1;
        step();
        mon_en = 1;
        step();
        clear_in();
        s_rs1 = 5;
        step();
        chk("t1_reg_write", 64'(reg_write), 64'(0));
        chk("t1_busy_vec", 64'(busy_vec), 64'(0));
        chk("t1_rs1_busy", 64'(rs1_busy), 64'(0));
        chk("t1_readies", 64'({wb0_ready, wb1_ready}), 64'(0));
        chk("t1_rd", 64'(rd), 64'(0));
        chk("t1_write_data", 64'(write_data), 64'(0));

        // 2: issue x7, observe hazard, retire through requester 1
        clear_in();
        s_iv = 1; s_ird = 7;
        step();
        clear_in();
        s_rs1 = 7;
        step();
        chk("t2_rs1_busy", 64'(rs1_busy), 64'(1));
        s_v1 = 1; s_rd1 = 7; s_d1 = 32'hDEADBEEF;
        step();
        chk("t2_wb1_ready", 64'(wb1_ready), 64'(1));
        clear_in();
        step();
        chk("t2_reg_write", 64'(reg_write), 64'(1));
        chk("t2_rd", 64'(rd), 64'(7));
        chk("t2_write_data", 64'(write_data), 64'(32'hDEADBEEF));
        chk("t2_busy7", 64'(busy_vec[7]), 64'(0));

        // 3: sustained contention alternates grants
        clear_in();
        s_v0 = 1; s_rd0 = 1; s_d0 = 32'h100;
        s_v1 = 1; s_rd1 = 9; s_d1 = 32'h900;
        for (int i = 0; i < 4; i++) begin
            step();
            gseq[i] = acc0 ? 0 : (acc1 ? 1 : 2);
            if (acc0) begin s_rd0 = s_rd0 + 1; s_d0 = s_d0 + 1; end
            if (acc1) begin s_rd1 = s_rd1 + 1; s_d1 = s_d1 + 1; end
        end
        for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), 64'(gseq[i]), 64'(i % 2));
        clear_in();
        step();

        // 4: hold blocks grants
        s_v0 = 1; s_rd0 = 20; s_d0 = 32'hCAFE; s_hold = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_ready_held", 64'(wb0_ready), 64'(0));
        end
        s_hold = 0;
        step();
        chk("t4_ready_release", 64'(wb0_ready), 64'(1));
        clear_in();
        step();

        // 5: same-cycle issue and retire of x3 keeps it busy
        s_iv = 1; s_ird = 3; s_v0 = 1; s_rd0 = 3; s_d0 = 32'h33;
        step();
        clear_in();
        step();
        chk("t5_busy3", 64'(busy_vec[3]), 64'(1));

        // 6: x0 writes, x0 issue, reset mid-stream
        s_v0 = 1; s_rd0 = 0; s_d0 = 32'h1234; s_iv = 1; s_ird = 0;
        step();
        chk("t6_wb0_ready", 64'(wb0_ready), 64'(1));
        clear_in();
        s_iv = 1; s_ird = 7;
        step();
        chk("t6_reg_write_x0", 64'(reg_write), 64'(0));
        clear_in();
        s_v0 = 1; s_rd0 = 5; s_d0 = 32'h55;
        step();
        chk("t6_busy_pre", 64'(busy_vec), 64'(32'h88));
        s_v0 = 0;
        s_v1 = 1; s_rd1 = 6; s_d1 = 32'h66; s_rst = 1;
        step();
        s_rst = 0;
        step();
        chk("t6_busy_post", 64'(busy_vec), 64'(0));
        chk("t6_reg_write_post", 64'(reg_write), 64'(0));
        clear_in();
        step();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            if (acc0 || !s_v0) begin
                s_v0 = ($urandom_range(0, 2) != 0); s_rd0 = 5'($urandom); s_d0 = $urandom;
            end
            if (acc1 || !s_v1) begin
                s_v1 = ($urandom_range(0, 2) != 0); s_rd1 = 5'($urandom); s_d1 = $urandom;
            end
            s_hold = ($urandom_range(0, 7) == 0);
            s_iv   = ($urandom_range(0, 1) == 1);
            s_ird  = 5'($urandom);
            s_rs1  = 5'($urandom);
            s_rs2  = 5'($urandom);
            s_rst  = ($urandom_range(0, 149) == 0);
            step();
        end
        clear_in();
        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
